// File: rtl/dst_track_pipe.sv
// +----------------------------------------------------------------------------+
// | dst_track_pipe: resolves destination register A3 at issue, tracks A3/Tnew  |
// | through STAGES slots, and derives stall and forward selects per query.     |
// | Optional: DST_TRACK_LATE_CANCEL_EN adds cancel_m to kill slot 0 on advance. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dst_track_pipe #(
  parameter int AW     = 5,
  parameter int STAGES = 3,
  parameter int TW     = 2,
  parameter int NQ     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [2:0]           in_regdst,
  input  logic [AW-1:0]        in_rt,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_cond,
  input  logic                 in_aluok,
  input  logic [TW-1:0]        in_tnew,
  input  logic                 stall,
  input  logic                 flush,
`ifdef DST_TRACK_LATE_CANCEL_EN
  input  logic                 cancel_m,
`endif
  input  logic [NQ*AW-1:0]     q_addr,
  input  logic [NQ*TW-1:0]     q_tuse,
  output logic [STAGES*AW-1:0] stage_a3,
  output logic [STAGES*TW-1:0] stage_tnew,
  output logic                 stall_req,
  output logic [NQ*2-1:0]      fwd_sel
);

  localparam logic [AW-1:0] c_LINK_REG = AW'(31);

  logic [AW-1:0] r_a3   [STAGES];
  logic [TW-1:0] r_tnew [STAGES];
  logic [AW-1:0] w_a3;
  logic          w_load;
  logic          w_cancel;
  logic [NQ-1:0] w_found;

  always_comb begin
    w_a3 = '0;
    case (in_regdst)
      3'd0:    w_a3 = in_rt;
      3'd1:    w_a3 = in_rd;
      3'd2:    w_a3 = c_LINK_REG;
      3'd3:    w_a3 = in_cond  ? c_LINK_REG : '0;
      3'd4:    w_a3 = in_aluok ? in_rd      : '0;
      3'd5:    w_a3 = in_cond  ? in_rt      : '0;
      default: w_a3 = '0;
    endcase
  end

  assign w_load = in_valid & ~stall & ~flush;

`ifdef DST_TRACK_LATE_CANCEL_EN
  assign w_cancel = cancel_m & (r_a3[0] != '0);
`else
  assign w_cancel = 1'b0;
`endif

  // Tnew is forced to 0 whenever the resolved destination is $0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3[0]   <= '0;
      r_tnew[0] <= '0;
    end else if (w_load) begin
      r_a3[0]   <= w_a3;
      r_tnew[0] <= (w_a3 == '0) ? '0 : in_tnew;
    end else begin
      r_a3[0]   <= '0;
      r_tnew[0] <= '0;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_slot
    logic w_kill;
    assign w_kill = (k == 1) ? w_cancel : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end else if (w_kill) begin
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end else begin
        r_a3[k]   <= r_a3[k-1];
        r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign stage_a3[k*AW +: AW]   = r_a3[k];
    assign stage_tnew[k*TW +: TW] = r_tnew[k];
  end

  // Only the youngest match decides forwarding; older matches are shadowed.
  always_comb begin
    stall_req = 1'b0;
    fwd_sel   = '0;
    w_found   = '0;
    for (int i = 0; i < NQ; i++) begin
      for (int k = 0; k < STAGES; k++) begin
        if ((q_addr[i*AW +: AW] != '0) && (r_a3[k] == q_addr[i*AW +: AW])) begin
          if (r_tnew[k] > q_tuse[i*TW +: TW]) stall_req = 1'b1;
          if (!w_found[i]) begin
            w_found[i] = 1'b1;
            if (r_tnew[k] == '0) fwd_sel[i*2 +: 2] = 2'(k + 1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dst_track_pipe.sv
// Directed testbench for dst_track_pipe (AW=5, STAGES=3, TW=2, NQ=2).
`default_nettype none

module tb_dst_track_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_regdst = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        in_cond = 1'b0;
  logic        in_aluok = 1'b0;
  logic [1:0]  in_tnew = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
`ifdef DST_TRACK_LATE_CANCEL_EN
  logic        cancel_m = 1'b0;
`endif
  logic [9:0]  q_addr = '0;
  logic [3:0]  q_tuse = '0;
  logic [14:0] stage_a3;
  logic [5:0]  stage_tnew;
  logic        stall_req;
  logic [3:0]  fwd_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dst_track_pipe #(.AW(5), .STAGES(3), .TW(2), .NQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_regdst  (in_regdst),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_cond    (in_cond),
    .in_aluok   (in_aluok),
    .in_tnew    (in_tnew),
    .stall      (stall),
    .flush      (flush),
`ifdef DST_TRACK_LATE_CANCEL_EN
    .cancel_m   (cancel_m),
`endif
    .q_addr     (q_addr),
    .q_tuse     (q_tuse),
    .stage_a3   (stage_a3),
    .stage_tnew (stage_tnew),
    .stall_req  (stall_req),
    .fwd_sel    (fwd_sel)
  );

  // Drive one D->E transfer on the next edge; returns 1ns after that edge.
  task automatic issue(input logic v, input logic [2:0] m, input logic [4:0] rt,
                       input logic [4:0] rd, input logic c, input logic a,
                       input logic [1:0] tn, input logic st, input logic fl);
    @(negedge clk);
    in_valid = v; in_regdst = m; in_rt = rt; in_rd = rd;
    in_cond = c; in_aluok = a; in_tnew = tn; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int j = 0; j < n; j++) issue(1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (stage_a3 !== 15'd0 || stage_tnew !== 6'd0 || stall_req !== 1'b0 || fwd_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_initial: a3=%h tnew=%h stall=%b fwd=%h, required all 0",
               stage_a3, stage_tnew, stall_req, fwd_sel);
    end
    reset = 1'b1;
    issue(1'b1, 3'd1, 5'd0, 5'd8,  1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 5'd0, 5'd9,  1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 5'd0, 5'd10, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    q_addr = {5'd0, 5'd10}; q_tuse = 4'd0;
    #1;
    checks++;
    if (stage_a3 !== {5'd8, 5'd9, 5'd10} || stage_tnew !== {2'd1, 2'd2, 2'd3} || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: a3=%h tnew=%h stall=%b, required a3=%h tnew=%h stall=1",
               stage_a3, stage_tnew, stall_req, {5'd8, 5'd9, 5'd10}, {2'd1, 2'd2, 2'd3});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stage_a3 !== 15'd0 || stage_tnew !== 6'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: a3=%h tnew=%h stall=%b, required all 0", stage_a3, stage_tnew, stall_req);
    end
    reset = 1'b1;
  endtask

  // Table of in_regdst cases with rt=6, rd=5, in_tnew=2.
  logic [2:0] rd_mode [10] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd5, 3'd7};
  logic       rd_cond [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       rd_alu  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0] rd_exp  [10] = '{5'd0, 5'd31, 5'd0, 5'd5, 5'd6, 5'd5, 5'd31, 5'd6, 5'd0, 5'd0};

  task automatic test_regdst;
    logic [1:0] exp_t;
    for (int n = 0; n < 10; n++) begin
      issue(1'b1, rd_mode[n], 5'd6, 5'd5, rd_cond[n], rd_alu[n], 2'd2, 1'b0, 1'b0);
      exp_t = (rd_exp[n] == 5'd0) ? 2'd0 : 2'd2;
      checks++;
      if (stage_a3[4:0] !== rd_exp[n] || stage_tnew[1:0] !== exp_t) begin
        errors++;
        $display("FAIL regdst_%0d: a3=%0d tnew=%0d, required a3=%0d tnew=%0d",
                 n, stage_a3[4:0], stage_tnew[1:0], rd_exp[n], exp_t);
      end
    end
  endtask

  task automatic test_countdown;
    logic       exp_stall [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] exp_fwd   [3] = '{4'd0, 4'd0, 4'd3};
    bubbles(3);
    q_addr = {5'd0, 5'd8}; q_tuse = 4'd0;
    issue(1'b1, 3'd1, 5'd0, 5'd8, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) bubbles(1);
      checks++;
      if (stall_req !== exp_stall[c] || fwd_sel !== exp_fwd[c]) begin
        errors++;
        $display("FAIL countdown_cyc%0d: stall=%b fwd=%h, required stall=%b fwd=%h",
                 c + 1, stall_req, fwd_sel, exp_stall[c], exp_fwd[c]);
      end
    end
    checks++;
    if (stage_tnew !== 6'd0 || stage_a3 !== {5'd8, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL countdown_sat: a3=%h tnew=%h, required a3=%h tnew=0", stage_a3, stage_tnew, {5'd8, 5'd0, 5'd0});
    end
    // Tnew 2 against Tuse 2 is just in time: no stall.
    issue(1'b1, 3'd1, 5'd0, 5'd8, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    q_tuse = {2'd0, 2'd2};
    #1;
    checks++;
    if (stall_req !== 1'b0 || fwd_sel !== 4'd0) begin
      errors++;
      $display("FAIL tuse_equal: stall=%b fwd=%h, required stall=0 fwd=0", stall_req, fwd_sel);
    end
    q_tuse = 4'd0;
  endtask

  task automatic test_back_to_back;
    bubbles(3);
    issue(1'b1, 3'd1, 5'd0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 5'd0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    q_addr = {5'd9, 5'd9}; q_tuse = 4'd0;
    #1;
    checks++;
    if (fwd_sel !== {2'd1, 2'd1} || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_youngest: fwd=%h stall=%b, required fwd=5 stall=0", fwd_sel, stall_req);
    end
    bubbles(1);
    checks++;
    if (fwd_sel !== {2'd2, 2'd2}) begin
      errors++;
      $display("FAIL b2b_shift: fwd=%h, required fwd=a", fwd_sel);
    end
    // Youngest match still pending shadows a ready older one.
    issue(1'b1, 3'd1, 5'd0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 5'd0, 5'd9, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    q_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL shadow_pending: fwd=%h stall=%b, required fwd=0 stall=1", fwd_sel, stall_req);
    end
  endtask

  task automatic test_zero_reg;
    bubbles(3);
    issue(1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    q_addr = 10'd0; q_tuse = 4'd0;
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || stall_req !== 1'b0 || stage_tnew[1:0] !== 2'd0) begin
      errors++;
      $display("FAIL zero_reg: fwd=%h stall=%b tnew0=%0d, required all 0", fwd_sel, stall_req, stage_tnew[1:0]);
    end
  endtask

  task automatic test_stall_flush;
    bubbles(3);
    issue(1'b1, 3'd1, 5'd0, 5'd6, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    issue(1'b1, 3'd1, 5'd0, 5'd7, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    stall = 1'b0; in_valid = 1'b0;
    q_addr = {5'd6, 5'd7}; q_tuse = 4'd0;
    #1;
    checks++;
    if (stage_a3 !== {5'd0, 5'd6, 5'd0} || fwd_sel !== {2'd2, 2'd0}) begin
      errors++;
      $display("FAIL stall_bubble: a3=%h fwd=%h, required a3=%h fwd=8", stage_a3, fwd_sel, {5'd0, 5'd6, 5'd0});
    end
    issue(1'b1, 3'd1, 5'd0, 5'd11, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
    issue(1'b1, 3'd1, 5'd0, 5'd11, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    q_addr = {5'd0, 5'd11};
    #1;
    checks++;
    if (stage_a3 !== {5'd0, 5'd0, 5'd0} || stage_tnew !== 6'd0 || fwd_sel !== 4'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: a3=%h tnew=%h fwd=%h stall=%b, required all 0",
               stage_a3, stage_tnew, fwd_sel, stall_req);
    end
  endtask

`ifdef DST_TRACK_LATE_CANCEL_EN
  task automatic test_cancel;
    bubbles(3);
    issue(1'b1, 3'd1, 5'd0, 5'd12, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    cancel_m = 1'b1;
    bubbles(1);
    cancel_m = 1'b0;
    q_addr = {5'd0, 5'd12}; q_tuse = 4'd0;
    #1;
    checks++;
    if (stage_a3[9:5] !== 5'd0 || fwd_sel !== 4'd0) begin
      errors++;
      $display("FAIL cancel_m: a3_1=%0d fwd=%h, required a3_1=0 fwd=0", stage_a3[9:5], fwd_sel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_regdst();
    test_countdown();
    test_back_to_back();
    test_zero_reg();
    test_stall_flush();
`ifdef DST_TRACK_LATE_CANCEL_EN
    test_cancel();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
